// File: rtl/d_cache_defs_pkg.sv
// rtl/d_cache_defs_pkg.sv - shared line geometry and mover state encoding for the d-cache data path
package d_cache_defs;

    localparam int BEATS  = 8;
    localparam int BEAT_W = $clog2(BEATS);
    localparam int SET_W  = 3;
    localparam int RAM_AW = SET_W + BEAT_W;
    localparam int BUS_AW = 32;
    localparam int DATA_W = 64;
    localparam int WEN_W  = DATA_W / 8;

    localparam logic [BEAT_W-1:0] LAST_BEAT = BEAT_W'(BEATS - 1);

    typedef enum logic [2:0] {
        IDLE,
        WB_REQ,
        WB_RD,
        WB_DATA,
        WB_RESP,
        FILL_REQ,
        FILL_DATA,
        DONE
    } mover_state_e;

endpackage

// File: rtl/d_cache_wb_hold.sv
// rtl/d_cache_wb_hold.sv - one-beat writeback holding register between the data RAM and the bus
module d_cache_wb_hold
    import d_cache_defs::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              i_load,
    input  logic [DATA_W-1:0] i_data,
    input  logic              i_ready,
    output logic              o_valid,
    output logic [DATA_W-1:0] o_data
);

    logic              r_valid;
    logic [DATA_W-1:0] r_data;

    // Capture the RAM beat on load and keep it until the bus accepts it
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
        end else if (i_load) begin
            r_data  <= i_data;
            r_valid <= ~i_ready;
        end else if (i_ready) begin
            r_valid <= 1'b0;
        end
    end

    // In the load cycle the RAM output is passed straight through so a beat costs only two cycles
    always_comb begin
        o_valid = i_load | r_valid;
        o_data  = i_load ? i_data : r_data;
    end

endmodule

// File: rtl/d_cache_line_mover.sv
// rtl/d_cache_line_mover.sv - miss sequencer: optional dirty-line writeback then refill; D_CACHE_FILL_FWD_EN adds fill forwarding
module d_cache_line_mover
    import d_cache_defs::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [SET_W-1:0]  req_set,
    input  logic              req_dirty,
    input  logic [BUS_AW-1:0] req_wb_addr,
    input  logic [BUS_AW-1:0] req_fill_addr,
    output logic              busy_o,
    output logic              done_o,
    output logic [RAM_AW-1:0] ram_addr_o,
    output logic [DATA_W-1:0] ram_wdata_o,
    output logic [WEN_W-1:0]  ram_wen_o,
    input  logic [DATA_W-1:0] ram_rdata_i,
    output logic              rd_req_valid,
    input  logic              rd_req_ready,
    output logic [BUS_AW-1:0] rd_req_addr,
    input  logic              rd_data_valid,
    input  logic [DATA_W-1:0] rd_data,
    output logic              wr_req_valid,
    input  logic              wr_req_ready,
    output logic [BUS_AW-1:0] wr_req_addr,
    output logic              wr_data_valid,
    input  logic              wr_data_ready,
    output logic [DATA_W-1:0] wr_data,
    output logic              wr_data_last,
    input  logic              wr_resp_valid
`ifdef D_CACHE_FILL_FWD_EN
    ,
    output logic              fwd_valid,
    output logic [BEAT_W-1:0] fwd_beat,
    output logic [DATA_W-1:0] fwd_data
`endif
);

    mover_state_e      r_state;
    logic [BEAT_W-1:0] r_beat;
    logic [SET_W-1:0]  r_set;
    logic [BUS_AW-1:0] r_wb_addr;
    logic [BUS_AW-1:0] r_fill_addr;
    logic              r_rd_pend;

    logic              w_fill_beat;
    logic              w_hold_load;
    logic              w_hold_ready;
    logic              w_hold_valid;
    logic [DATA_W-1:0] w_hold_data;

    // Move sequencer: request latch, phase transitions and the shared beat counter
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_beat      <= '0;
            r_set       <= '0;
            r_wb_addr   <= '0;
            r_fill_addr <= '0;
            r_rd_pend   <= 1'b0;
        end else begin
            r_rd_pend <= (r_state == WB_RD);
            case (r_state)
                IDLE: begin
                    if (req_valid) begin
                        r_set       <= req_set;
                        r_wb_addr   <= req_wb_addr;
                        r_fill_addr <= req_fill_addr;
                        r_beat      <= '0;
                        r_state     <= req_dirty ? WB_REQ : FILL_REQ;
                    end
                end
                WB_REQ: begin
                    if (wr_req_ready) r_state <= WB_RD;
                end
                WB_RD: begin
                    r_state <= WB_DATA;
                end
                WB_DATA: begin
                    if (wr_data_ready) begin
                        if (r_beat == LAST_BEAT) begin
                            r_state <= WB_RESP;
                        end else begin
                            r_beat  <= r_beat + 1'b1;
                            r_state <= WB_RD;
                        end
                    end
                end
                WB_RESP: begin
                    if (wr_resp_valid) begin
                        r_beat  <= '0;
                        r_state <= FILL_REQ;
                    end
                end
                FILL_REQ: begin
                    if (rd_req_ready) r_state <= FILL_DATA;
                end
                FILL_DATA: begin
                    if (rd_data_valid) begin
                        r_beat <= r_beat + 1'b1;
                        if (r_beat == LAST_BEAT) r_state <= DONE;
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    // The RAM beat read in WB_RD arrives in the first WB_DATA cycle, which is when it is loaded
    assign w_hold_load  = (r_state == WB_DATA) && r_rd_pend;
    assign w_hold_ready = (r_state == WB_DATA) && wr_data_ready;

    d_cache_wb_hold u_wb_hold (
        .clk     (clk),
        .rst     (rst),
        .i_load  (w_hold_load),
        .i_data  (ram_rdata_i),
        .i_ready (w_hold_ready),
        .o_valid (w_hold_valid),
        .o_data  (w_hold_data)
    );

    // Fill beats are written in the cycle they arrive; a reset cycle never writes
    assign w_fill_beat = (r_state == FILL_DATA) && rd_data_valid && !rst;

    // Handshake and RAM port decode from the current phase
    always_comb begin
        req_ready     = (r_state == IDLE);
        busy_o        = (r_state != IDLE);
        done_o        = (r_state == DONE);
        wr_req_valid  = (r_state == WB_REQ);
        wr_req_addr   = r_wb_addr;
        rd_req_valid  = (r_state == FILL_REQ);
        rd_req_addr   = r_fill_addr;
        wr_data_valid = (r_state == WB_DATA) && w_hold_valid;
        wr_data       = w_hold_data;
        wr_data_last  = wr_data_valid && (r_beat == LAST_BEAT);
        ram_addr_o    = {r_set, r_beat};
        ram_wdata_o   = rd_data;
        ram_wen_o     = w_fill_beat ? {WEN_W{1'b1}} : {WEN_W{1'b0}};
    end

`ifdef D_CACHE_FILL_FWD_EN
    // Each accepted fill beat is also offered to the core for an early restart
    always_comb begin
        fwd_valid = w_fill_beat;
        fwd_beat  = r_beat;
        fwd_data  = rd_data;
    end
`endif

endmodule

// File: tb/tb_d_cache_line_mover.sv
// tb/tb_d_cache_line_mover.sv - self-checking bench for d_cache_line_mover (D_CACHE_FILL_FWD_EN optional)
module tb_d_cache_line_mover;
    import d_cache_defs::*;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              req_valid = 1'b0;
    logic              req_ready;
    logic [SET_W-1:0]  req_set = '0;
    logic              req_dirty = 1'b0;
    logic [BUS_AW-1:0] req_wb_addr = '0;
    logic [BUS_AW-1:0] req_fill_addr = '0;
    logic              busy_o;
    logic              done_o;
    logic [RAM_AW-1:0] ram_addr_o;
    logic [DATA_W-1:0] ram_wdata_o;
    logic [WEN_W-1:0]  ram_wen_o;
    logic [DATA_W-1:0] ram_rdata_i;
    logic              rd_req_valid;
    logic              rd_req_ready = 1'b0;
    logic [BUS_AW-1:0] rd_req_addr;
    logic              rd_data_valid = 1'b0;
    logic [DATA_W-1:0] rd_data = '0;
    logic              wr_req_valid;
    logic              wr_req_ready = 1'b0;
    logic [BUS_AW-1:0] wr_req_addr;
    logic              wr_data_valid;
    logic              wr_data_ready = 1'b0;
    logic [DATA_W-1:0] wr_data;
    logic              wr_data_last;
    logic              wr_resp_valid = 1'b0;
`ifdef D_CACHE_FILL_FWD_EN
    logic              fwd_valid;
    logic [BEAT_W-1:0] fwd_beat;
    logic [DATA_W-1:0] fwd_data;
`endif

    int checks = 0;
    int errors = 0;

    logic [DATA_W-1:0] mem [0:63];
    logic              pre_en = 1'b0;
    logic [RAM_AW-1:0] pre_addr = '0;
    logic [DATA_W-1:0] pre_data = '0;

    always #5 clk = ~clk;

    d_cache_line_mover dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_set       (req_set),
        .req_dirty     (req_dirty),
        .req_wb_addr   (req_wb_addr),
        .req_fill_addr (req_fill_addr),
        .busy_o        (busy_o),
        .done_o        (done_o),
        .ram_addr_o    (ram_addr_o),
        .ram_wdata_o   (ram_wdata_o),
        .ram_wen_o     (ram_wen_o),
        .ram_rdata_i   (ram_rdata_i),
        .rd_req_valid  (rd_req_valid),
        .rd_req_ready  (rd_req_ready),
        .rd_req_addr   (rd_req_addr),
        .rd_data_valid (rd_data_valid),
        .rd_data       (rd_data),
        .wr_req_valid  (wr_req_valid),
        .wr_req_ready  (wr_req_ready),
        .wr_req_addr   (wr_req_addr),
        .wr_data_valid (wr_data_valid),
        .wr_data_ready (wr_data_ready),
        .wr_data       (wr_data),
        .wr_data_last  (wr_data_last),
        .wr_resp_valid (wr_resp_valid)
`ifdef D_CACHE_FILL_FWD_EN
        ,
        .fwd_valid     (fwd_valid),
        .fwd_beat      (fwd_beat),
        .fwd_data      (fwd_data)
`endif
    );

    // Data RAM model: byte write enables, one-cycle synchronous read
    always @(posedge clk) begin
        if (pre_en) begin
            mem[pre_addr] <= pre_data;
        end else begin
            for (int b = 0; b < WEN_W; b++)
                if (ram_wen_o[b]) mem[ram_addr_o][b*8 +: 8] <= ram_wdata_o[b*8 +: 8];
        end
        ram_rdata_i <= mem[ram_addr_o];
    end

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic preload(input logic [SET_W-1:0] s, input logic [DATA_W-1:0] base);
        for (int i = 0; i < BEATS; i++) begin
            @(negedge clk);
            pre_en   = 1'b1;
            pre_addr = {s, BEAT_W'(i)};
            pre_data = base + DATA_W'(i);
        end
        @(negedge clk);
        pre_en = 1'b0;
    endtask

    task automatic chk_line(input string tag, input logic [SET_W-1:0] s, input logic [DATA_W-1:0] base);
        for (int i = 0; i < BEATS; i++)
            chk($sformatf("%s_mem%0d", tag, i), 128'(mem[{s, BEAT_W'(i)}]), 128'(base + DATA_W'(i)));
    endtask

    // Full move with a responsive bus; writeback data expected as 0xA0+beat
    task automatic run_move(input string tag, input logic [SET_W-1:0] s, input logic dirty,
                            input logic [DATA_W-1:0] fbase, input int stall_beat, input int stall_len);
        int   nwb, nfill, stall_cnt, last_hs, resp_cyc, last_fill;
        logic fill_go, rdreq_seen, finished;
        nwb = 0; nfill = 0; stall_cnt = 0; last_hs = -1; resp_cyc = -1; last_fill = -1;
        fill_go = 1'b0; rdreq_seen = 1'b0; finished = 1'b0;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            @(negedge clk);
            req_valid     = (cyc == 0);
            req_set       = s;
            req_dirty     = dirty;
            req_wb_addr   = 32'h0000_2000;
            req_fill_addr = 32'h0000_3000;
            wr_req_ready  = 1'b1;
            rd_req_ready  = 1'b1;
            wr_data_ready = !(nwb == stall_beat && stall_cnt < stall_len);
            wr_resp_valid = (cyc == 3) || (nwb == BEATS && cyc == last_hs + 2);
            if (wr_resp_valid && nwb == BEATS) resp_cyc = cyc;
            rd_data_valid = fill_go && nfill < BEATS;
            rd_data       = fbase + DATA_W'(nfill);
            #1;
            if (wr_req_valid) chk({tag, "_wr_addr"}, 128'(wr_req_addr), 128'(32'h0000_2000));
            if (wr_data_valid) begin
                chk($sformatf("%s_wr_data%0d", tag, nwb), 128'(wr_data), 128'(64'hA0 + 64'(nwb)));
                chk($sformatf("%s_wr_last%0d", tag, nwb), 128'(wr_data_last), 128'(nwb == BEATS - 1));
                if (wr_data_ready) begin
                    if (last_hs >= 0)
                        chk($sformatf("%s_wr_gap%0d", tag, nwb), 128'(cyc - last_hs),
                            128'(2 + ((nwb == stall_beat) ? stall_len : 0)));
                    last_hs = cyc;
                    nwb++;
                end else begin
                    stall_cnt++;
                end
            end
            if (rd_req_valid && !rdreq_seen) begin
                chk({tag, "_fill_after_resp"}, 128'(!dirty || (resp_cyc >= 0 && cyc > resp_cyc)), 128'(1));
                chk({tag, "_rd_addr"}, 128'(rd_req_addr), 128'(32'h0000_3000));
                rdreq_seen = 1'b1;
                fill_go    = 1'b1;
            end
            if (rd_data_valid) begin
                chk($sformatf("%s_fill_wen%0d", tag, nfill), 128'(ram_wen_o), 128'(8'hFF));
                chk($sformatf("%s_fill_ram%0d", tag, nfill), 128'({ram_addr_o, ram_wdata_o}),
                    128'({s, BEAT_W'(nfill), fbase + DATA_W'(nfill)}));
`ifdef D_CACHE_FILL_FWD_EN
                chk($sformatf("%s_fwd%0d", tag, nfill), 128'({fwd_valid, fwd_beat, fwd_data}),
                    128'({1'b1, BEAT_W'(nfill), fbase + DATA_W'(nfill)}));
`endif
                nfill++;
                last_fill = cyc;
            end else begin
                chk($sformatf("%s_idle_wen_c%0d", tag, cyc), 128'(ram_wen_o), 128'(0));
            end
            if (done_o) begin
                chk({tag, "_done_cycle"}, 128'(cyc), 128'(last_fill + 1));
                chk({tag, "_counts"}, 128'({nwb, nfill}), 128'({(dirty ? BEATS : 0), BEATS}));
                finished = 1'b1;
            end
        end
        if (!finished) chk({tag, "_timeout"}, 128'(finished), 128'(1));
        @(negedge clk);
        req_valid = 1'b0; wr_resp_valid = 1'b0; rd_data_valid = 1'b0;
        wr_data_ready = 1'b0; rd_req_ready = 1'b0; wr_req_ready = 1'b0;
    endtask

    typedef struct {
        logic              rv;
        logic [SET_W-1:0]  s;
        logic              rrr;
        logic              dv;
        logic [DATA_W-1:0] d;
        logic [5:0]        ec;
        logic [WEN_W-1:0]  ew;
        logic [RAM_AW-1:0] ea;
    } vec_t;

    vec_t vq[$];

    function automatic void addv(input logic rv, input logic [SET_W-1:0] s, input logic rrr, input logic dv,
                                 input logic [DATA_W-1:0] d, input logic [5:0] ec, input logic [WEN_W-1:0] ew,
                                 input logic [RAM_AW-1:0] ea);
        vec_t v;
        v.rv = rv; v.s = s; v.rrr = rrr; v.dv = dv; v.d = d; v.ec = ec; v.ew = ew; v.ea = ea;
        vq.push_back(v);
    endfunction

    // ctrl = {req_ready, busy_o, done_o, wr_req_valid, wr_data_valid, rd_req_valid}
    localparam logic [5:0] C_IDLE = 6'b100000;
    localparam logic [5:0] C_FREQ = 6'b010001;
    localparam logic [5:0] C_BUSY = 6'b010000;
    localparam logic [5:0] C_DONE = 6'b011000;

    initial begin
        // Clean miss, set 3, back-to-back beats; a request held through DONE starts the next move in IDLE
        addv(1, 3, 0, 0, 0, C_IDLE, 0, 0);
        addv(0, 3, 1, 0, 0, C_FREQ, 0, 0);
        for (int i = 0; i < BEATS; i++) addv(0, 3, 0, 1, 64'h10 + 64'(i), C_BUSY, 8'hFF, RAM_AW'(24 + i));
        addv(1, 6, 0, 0, 0, C_DONE, 0, 0);
        // Gapped refill, set 6; stray rd_data_valid in FILL_REQ and DONE must not write
        addv(1, 6, 0, 0, 0, C_IDLE, 0, 0);
        addv(0, 6, 0, 1, 64'hDEAD, C_FREQ, 0, 0);
        addv(0, 6, 1, 0, 0, C_FREQ, 0, 0);
        for (int i = 0; i < BEATS; i++) begin
            addv(0, 6, 0, 0, 0, C_BUSY, 0, 0);
            addv(0, 6, 0, 1, 64'h60 + 64'(i), C_BUSY, 8'hFF, RAM_AW'(48 + i));
        end
        addv(0, 6, 0, 1, 64'hBEEF, C_DONE, 0, 0);
        addv(0, 6, 0, 0, 0, C_IDLE, 0, 0);

        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("reset_ctrl", 128'({req_ready, busy_o, done_o, wr_req_valid, wr_data_valid, rd_req_valid}), 128'(C_IDLE));
        chk("reset_wen", 128'({ram_wen_o, wr_data_last}), 128'(0));

        preload(3'd5, 64'hA0);
        preload(3'd2, 64'hEE);

        for (int i = 0; i < vq.size(); i++) begin
            @(negedge clk);
            req_valid = vq[i].rv; req_set = vq[i].s; req_dirty = 1'b0;
            rd_req_ready = vq[i].rrr; rd_data_valid = vq[i].dv; rd_data = vq[i].d;
            #1;
            chk($sformatf("vec%0d_ctrl", i),
                128'({req_ready, busy_o, done_o, wr_req_valid, wr_data_valid, rd_req_valid}), 128'(vq[i].ec));
            chk($sformatf("vec%0d_wen", i), 128'(ram_wen_o), 128'(vq[i].ew));
            if (vq[i].ew != 0)
                chk($sformatf("vec%0d_ram", i), 128'({ram_addr_o, ram_wdata_o}), 128'({vq[i].ea, vq[i].d}));
`ifdef D_CACHE_FILL_FWD_EN
            chk($sformatf("vec%0d_fwd_valid", i), 128'(fwd_valid), 128'(vq[i].ew != 0));
            if (vq[i].ew != 0)
                chk($sformatf("vec%0d_fwd", i), 128'({fwd_beat, fwd_data}), 128'({vq[i].ea[BEAT_W-1:0], vq[i].d}));
`endif
        end
        @(negedge clk);
        req_valid = 1'b0; rd_data_valid = 1'b0; rd_req_ready = 1'b0;
        @(negedge clk);
        chk_line("t1", 3'd3, 64'h10);
        chk_line("t4", 3'd6, 64'h60);

        // Dirty miss on set 5, then the same with a 3-cycle stall on beat 2
        run_move("t2", 3'd5, 1'b1, 64'hC0, -1, 0);
        chk_line("t2", 3'd5, 64'hC0);
        preload(3'd5, 64'hA0);
        run_move("t3", 3'd5, 1'b1, 64'hD0, 2, 3);
        chk_line("t3", 3'd5, 64'hD0);

        // Reset in FILL_DATA after beat 4 on set 2
        @(negedge clk);
        req_valid = 1'b1; req_set = 3'd2; req_dirty = 1'b0;
        @(negedge clk);
        req_valid = 1'b0; rd_req_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            rd_req_ready = 1'b0; rd_data_valid = 1'b1; rd_data = 64'h50 + 64'(i);
            #1;
            chk($sformatf("t5_wen%0d", i), 128'({ram_wen_o, ram_addr_o}), 128'({8'hFF, 3'd2, BEAT_W'(i)}));
        end
        @(negedge clk);
        rst = 1'b1; rd_data = 64'h55;
        #1;
        chk("t5_rst_wen", 128'(ram_wen_o), 128'(0));
        @(negedge clk);
        rst = 1'b0; rd_data = 64'h56;
        #1;
        chk("t5_after_rst_ctrl", 128'({req_ready, busy_o, done_o, wr_req_valid, wr_data_valid, rd_req_valid}),
            128'(C_IDLE));
        chk("t5_after_rst_wen", 128'(ram_wen_o), 128'(0));
        @(negedge clk);
        rd_data_valid = 1'b0;
        for (int i = 0; i < BEATS; i++)
            chk($sformatf("t5_mem%0d", i), 128'(mem[{3'd2, BEAT_W'(i)}]),
                128'((i < 5) ? 64'h50 + 64'(i) : 64'hEE + 64'(i)));
        run_move("t5b", 3'd2, 1'b0, 64'h70, -1, 0);
        chk_line("t5b", 3'd2, 64'h70);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach the summary, got timeout expected finish");
        $fatal(1);
    end

endmodule
